// File: rtl/pe_feeder.sv
// pe_feeder: sequences weight loading, weight switch and input streaming
// for one systolic PE column/row. Data words pass through unmodified;
// every pe_* output is a register reflecting the previous cycle's handshake.
module pe_feeder #(
  parameter int ROWS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] w_data_in,
  input  logic               w_valid_in,
  output logic               w_ready_out,
  input  logic signed [15:0] x_data_in,
  input  logic               x_valid_in,
  output logic               x_ready_out,
  input  logic               x_last_in,
  input  logic               start_in,
  output logic signed [15:0] pe_weight_out,
  output logic               pe_accept_w_out,
  output logic signed [15:0] pe_input_out,
  output logic               pe_valid_out,
  output logic               pe_switch_out,
  output logic               pe_enabled_out,
  output logic               busy_out,
  output logic               done_out
);

  localparam int CW = (ROWS < 2) ? 1 : $clog2(ROWS + 1);
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    SWITCH = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   w_cnt_q, w_cnt_d;
  logic            en_q;
  logic signed [15:0] weight_q, input_q;
  logic            accept_q, valid_q, switch_q;
  logic            w_fire, x_fire;

  // Handshakes are held off until the PE column is enabled, so nothing is
  // accepted during reset or in the first cycle after it.
  assign w_ready_out = en_q && (w_cnt_q < ROWS_C) &&
                       (state_q == IDLE || state_q == LOAD_W || state_q == STREAM);
  assign x_ready_out = en_q && (state_q == SWITCH || state_q == STREAM);
  assign w_fire      = w_valid_in && w_ready_out;
  assign x_fire      = x_valid_in && x_ready_out;

  assign busy_out        = (state_q != IDLE);
  assign done_out        = (state_q == DONE);
  assign pe_weight_out   = weight_q;
  assign pe_accept_w_out = accept_q;
  assign pe_input_out    = input_q;
  assign pe_valid_out    = valid_q;
  assign pe_switch_out   = switch_q;
  assign pe_enabled_out  = en_q;

  // Next-state and weight-count logic; SWITCH hands the loaded weights to
  // the PEs, so the count restarts there for preloading the next tile.
  always_comb begin
    state_d = state_q;
    w_cnt_d = w_cnt_q;
    if (w_fire) w_cnt_d = w_cnt_q + 1'b1;
    case (state_q)
      IDLE:    if (start_in) state_d = (w_cnt_q == ROWS_C) ? SWITCH : LOAD_W;
      LOAD_W:  if (w_cnt_q == ROWS_C) state_d = SWITCH;
      SWITCH: begin
        w_cnt_d = '0;
        state_d = (x_fire && x_last_in) ? DONE : STREAM;
      end
      STREAM:  if (x_fire && x_last_in) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered PE-side buses; stalls become zero bubbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      w_cnt_q  <= '0;
      en_q     <= 1'b0;
      weight_q <= '0;
      accept_q <= 1'b0;
      input_q  <= '0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_cnt_q  <= w_cnt_d;
      en_q     <= 1'b1;
      weight_q <= w_fire ? w_data_in : 16'sd0;
      accept_q <= w_fire;
      input_q  <= x_fire ? x_data_in : 16'sd0;
      valid_q  <= x_fire;
      switch_q <= (state_q == SWITCH);
    end
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter: ROWS, default 4, number of weights per tile (PE column depth); legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 w_data_in  input  16  signed weight word from host.
REQ-005 w_valid_in / w_ready_out  input / output  1 each  weight-stream handshake; a transfer occurs when both are 1 on a rising edge.
REQ-006 x_data_in  input  16  signed input activation from host.
REQ-007 x_valid_in / x_ready_out  input / output  1 each  input-stream handshake, same transfer rule.
REQ-008 x_last_in  input  1  marks final input of tile; sampled only on an x transfer.
REQ-009 start_in  input  1  begin tile; honoured only in IDLE.
REQ-010 pe_weight_out / pe_accept_w_out  output  16 / 1  north weight bus and accept-weight strobe to PE column.
REQ-011 pe_input_out / pe_valid_out / pe_switch_out  output  16 / 1 / 1  west input bus, valid, and weight-switch flag to PE row.
REQ-012 pe_enabled_out  output  1  PE enable.
REQ-013 busy_out  output  1  high when state is not IDLE.
REQ-014 done_out  output  1  one-cycle tile-complete pulse.

Function
REQ-015 States: IDLE, LOAD_W, SWITCH, STREAM, DONE; internal weight counter w_cnt, 0..ROWS.
REQ-016 All pe_* outputs are registered; each reflects the handshake of the previous cycle.
REQ-017 w_ready_out = 1 iff w_cnt < ROWS and state is IDLE, LOAD_W or STREAM; 0 in SWITCH and DONE.
REQ-018 Per weight transfer: w_cnt increments; next cycle pe_accept_w_out = 1, pe_weight_out = w_data_in. Without transfer: both 0 next cycle.
REQ-019 IDLE + start_in: w_cnt == ROWS -> SWITCH; otherwise -> LOAD_W. start_in outside IDLE ignored.
REQ-020 LOAD_W: stays until w_cnt == ROWS, then -> SWITCH; this includes the cycle after the ROWS-th transfer.
REQ-021 SWITCH: one cycle; x_ready_out = 1; w_cnt cleared to 0; next cycle pe_switch_out = 1.
REQ-022 pe_switch_out is 1 for exactly one cycle per tile; otherwise 0.
REQ-023 The first input may transfer in SWITCH, so pe_valid_out and pe_switch_out may be high in the same cycle.
REQ-024 STREAM: x_ready_out = 1.
REQ-025 STREAM: weight transfers continue and preload the next tile's weights into the PE inactive registers.
REQ-026 x transfer in SWITCH or STREAM: next cycle pe_valid_out = 1, pe_input_out = x_data_in. Without transfer: both 0 next cycle.
REQ-027 x transfer with x_last_in = 1 -> DONE, in SWITCH or STREAM.
REQ-028 x_ready_out = 0 in IDLE, LOAD_W and DONE.
REQ-029 DONE: done_out = 1 for that one cycle, then -> IDLE; preloaded w_cnt is retained.
REQ-030 pe_enabled_out = 1 from the first edge after rst deasserts; the feeder never lowers it while out of reset, since that would clear PE weights.
REQ-031 Data is passed unmodified, no arithmetic; 16-bit signed Q-format is the same as the PE fxp units.
REQ-032 Host stalls (valid low) insert zero-valid bubbles on PE buses; order is preserved.

Reset
REQ-033 rst = 0 at an edge: state -> IDLE, w_cnt = 0, and every output = 0 next cycle, including pe_enabled_out, busy_out and done_out.
REQ-034 Reset mid-operation discards partial weights and inputs; no done_out pulse is issued.

Verification
REQ-035 Cold tile, ROWS=4: 4 weights {1,2,3,4} back-to-back, start, 3 inputs with last on the 3rd -> pe_accept_w_out high 4 cycles carrying 1..4; pe_switch_out single pulse coincident with first pe_valid_out; done_out one pulse; busy_out falls next cycle.
REQ-036 Preload: during STREAM supply 4 weights {5,6,7,8}, then start -> FSM goes IDLE->SWITCH with no LOAD_W; w_ready_out stays 0 after the 4th weight until SWITCH clears w_cnt.
REQ-037 Backpressure: x_valid_in toggles 1,0,1 -> pe_valid_out 1,0,1 with pe_input_out 0 in the gap.
REQ-038 Single-input tile: x_last_in on first transfer in SWITCH -> one valid cycle with switch; DONE next cycle.
REQ-039 Reset mid-LOAD_W after 2 weights -> all outputs 0 next cycle; start then requires 4 new weights.
REQ-040 start_in pulsed during STREAM -> ignored, no extra switch pulse.
